// File: rtl/game_state_controller.sv
// Number-guessing game controller.
// A round starts on a submit event in IDLE, latching random_n as the secret
// target. Each later event compares guess against the target, reports
// too low / too high / correct on hint, and counts down tries_left. The round
// ends in WIN or LOSE; one more event returns to IDLE.
// Ports:
//   clk          - clock, rising edge
//   master_reset - synchronous active-high reset
//   submit       - player button (level); only a rising edge is an event
//   random_n     - free-running random value, latched at round start
//   guess        - player guess, sampled on an event
//   state        - FSM state code (IDLE=0, GUESS=1, WIN=2, LOSE=3)
//   hint         - 00 none, 01 too low, 10 too high, 11 correct
//   tries_left   - guesses remaining in the round
//   score        - rounds won since reset, saturating
//   over         - high in WIN or LOSE
module game_state_controller #(
   parameter int unsigned N_WIDTH   = 4,
   parameter int unsigned MAX_TRIES = 7,
   parameter int unsigned SCORE_W   = 8
) (
   input  logic               clk,
   input  logic               master_reset,
   input  logic               submit,
   input  logic [N_WIDTH-1:0] random_n,
   input  logic [N_WIDTH-1:0] guess,
   output logic [2:0]         state,
   output logic [1:0]         hint,
   output logic [7:0]         tries_left,
   output logic [SCORE_W-1:0] score,
   output logic               over
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GUESS = 3'd1;
   localparam logic [2:0] S_WIN   = 3'd2;
   localparam logic [2:0] S_LOSE  = 3'd3;

   localparam logic [1:0] H_NONE = 2'b00;
   localparam logic [1:0] H_LOW  = 2'b01;
   localparam logic [1:0] H_HIGH = 2'b10;
   localparam logic [1:0] H_HIT  = 2'b11;

   localparam logic [7:0]         TRIES_INIT = 8'(MAX_TRIES);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

   logic               submit_q;
   logic               armed;
   logic               evt;
   logic [N_WIDTH-1:0] target;

   logic [2:0]         state_nxt;
   logic [1:0]         hint_nxt;
   logic [7:0]         tries_nxt;
   logic [SCORE_W-1:0] score_nxt;
   logic [N_WIDTH-1:0] target_nxt;

   // armed blocks a button that was already held through reset from firing
   // until it has been seen low once.
   assign evt  = submit & ~submit_q & armed;
   assign over = (state == S_WIN) || (state == S_LOSE);

   // Edge detector and arming flag.
   always_ff @(posedge clk) begin
      if (master_reset) begin
         submit_q <= 1'b0;
         armed    <= ~submit;
      end else begin
         submit_q <= submit;
         if (!submit) armed <= 1'b1;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (master_reset) begin
         state      <= S_IDLE;
         hint       <= H_NONE;
         tries_left <= 8'd0;
         score      <= '0;
         target     <= '0;
      end else begin
         state      <= state_nxt;
         hint       <= hint_nxt;
         tries_left <= tries_nxt;
         score      <= score_nxt;
         target     <= target_nxt;
      end
   end

   // Next-state and next-value logic; everything holds without an event.
   always_comb begin
      state_nxt  = state;
      hint_nxt   = hint;
      tries_nxt  = tries_left;
      score_nxt  = score;
      target_nxt = target;
      case (state)
         S_IDLE: begin
            if (evt) begin
               target_nxt = random_n;
               tries_nxt  = TRIES_INIT;
               hint_nxt   = H_NONE;
               state_nxt  = S_GUESS;
            end
         end
         S_GUESS: begin
            if (evt) begin
               if (guess == target) begin
                  hint_nxt  = H_HIT;
                  state_nxt = S_WIN;
                  if (score != SCORE_MAX) score_nxt = score + SCORE_W'(1);
               end else begin
                  hint_nxt = (guess < target) ? H_LOW : H_HIGH;
                  // <= 1 rather than == 1 so a zero count can never wrap.
                  if (tries_left <= 8'd1) begin
                     tries_nxt = 8'd0;
                     state_nxt = S_LOSE;
                  end else begin
                     tries_nxt = tries_left - 8'd1;
                  end
               end
            end
         end
         S_WIN, S_LOSE: begin
            if (evt) begin
               hint_nxt  = H_NONE;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_game_state_controller.sv
module tb_game_state_controller;

   logic       clk = 1'b0;
   logic       master_reset;
   logic       submit;
   logic [3:0] random_n;
   logic [3:0] guess;
   logic [2:0] state;
   logic [1:0] res_hint;
   logic [7:0] tries_left;
   logic [7:0] score;
   logic       over;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   game_state_controller #(.N_WIDTH(4), .MAX_TRIES(3), .SCORE_W(8)) dut (
      .clk(clk),
      .master_reset(master_reset),
      .submit(submit),
      .random_n(random_n),
      .guess(guess),
      .state(state),
      .hint(res_hint),
      .tries_left(tries_left),
      .score(score),
      .over(over)
   );

   typedef struct {
      logic       rst;
      logic       sub;
      logic [3:0] rnd;
      logic [3:0] gs;
      logic [2:0] e_state;
      logic [1:0] e_hint;
      logic [7:0] e_tries;
      logic [7:0] e_score;
   } vec_t;

   vec_t vecs[28];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int es, input int eh,
                          input int et, input int esc);
      chk({tag, ".state"}, int'(state), es);
      chk({tag, ".hint"},  int'(res_hint), eh);
      chk({tag, ".tries"}, int'(tries_left), et);
      chk({tag, ".score"}, int'(score), esc);
      chk({tag, ".over"},  int'(over), int'(es == 2 || es == 3));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One button press: release for a cycle, then press for a cycle.
   task automatic press();
      submit = 1'b0;
      tick();
      submit = 1'b1;
      tick();
   endtask

   task automatic do_reset();
      master_reset = 1'b1;
      submit       = 1'b0;
      tick();
      master_reset = 1'b0;
   endtask

   // IDLE -> GUESS (target=r) -> WIN -> IDLE.
   task automatic win_round(input logic [3:0] r);
      random_n = r;
      press();
      guess = r;
      press();
      press();
   endtask

   initial begin
      // rst sub rnd gs | state hint tries score
      vecs[0]  = '{1, 0, 9, 0,  0, 0, 0, 0};
      vecs[1]  = '{0, 0, 9, 0,  0, 0, 0, 0};
      vecs[2]  = '{0, 1, 9, 0,  1, 0, 3, 0};
      vecs[3]  = '{0, 1, 5, 0,  1, 0, 3, 0};  // held: no second event
      vecs[4]  = '{0, 0, 5, 9,  1, 0, 3, 0};
      vecs[5]  = '{0, 1, 5, 9,  2, 3, 3, 1};  // win
      vecs[6]  = '{0, 0, 5, 9,  2, 3, 3, 1};
      vecs[7]  = '{0, 1, 5, 9,  0, 0, 3, 1};  // restart
      vecs[8]  = '{0, 0, 9, 0,  0, 0, 3, 1};
      vecs[9]  = '{0, 1, 9, 0,  1, 0, 3, 1};
      vecs[10] = '{0, 0, 2, 4,  1, 0, 3, 1};  // random_n change mid-round
      vecs[11] = '{0, 1, 2, 4,  1, 1, 2, 1};  // too low
      vecs[12] = '{0, 0, 2, 12, 1, 1, 2, 1};
      vecs[13] = '{0, 1, 2, 12, 1, 2, 1, 1};  // too high
      vecs[14] = '{0, 0, 2, 0,  1, 2, 1, 1};
      vecs[15] = '{0, 1, 2, 0,  3, 1, 0, 1};  // lose
      vecs[16] = '{0, 0, 2, 0,  3, 1, 0, 1};
      vecs[17] = '{0, 1, 2, 0,  0, 0, 0, 1};
      vecs[18] = '{0, 0, 9, 0,  0, 0, 0, 1};
      vecs[19] = '{0, 1, 9, 0,  1, 0, 3, 1};
      vecs[20] = '{0, 0, 9, 15, 1, 0, 3, 1};
      vecs[21] = '{0, 1, 9, 15, 1, 2, 2, 1};  // unsigned: 15 > 9
      vecs[22] = '{0, 0, 9, 15, 1, 2, 2, 1};
      vecs[23] = '{1, 1, 9, 9,  0, 0, 0, 0};  // reset beats event
      vecs[24] = '{0, 1, 9, 9,  0, 0, 0, 0};  // held through reset
      vecs[25] = '{0, 1, 9, 9,  0, 0, 0, 0};
      vecs[26] = '{0, 0, 3, 9,  0, 0, 0, 0};
      vecs[27] = '{0, 1, 3, 9,  1, 0, 3, 0};

      master_reset = 1'b1;
      submit       = 1'b0;
      random_n     = 4'd0;
      guess        = 4'd0;
      tick();

      for (int i = 0; i < 28; i++) begin
         master_reset = vecs[i].rst;
         submit       = vecs[i].sub;
         random_n     = vecs[i].rnd;
         guess        = vecs[i].gs;
         tick();
         chk_all($sformatf("vec%0d", i), int'(vecs[i].e_state), int'(vecs[i].e_hint),
                 int'(vecs[i].e_tries), int'(vecs[i].e_score));
      end

      // Held button in IDLE for 10 cycles: one transition, no decrement.
      do_reset();
      tick();
      random_n = 4'd7;
      submit   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_all($sformatf("held%0d", i), 1, 0, 3, 0);
      end

      // Mid-round reset with score 5 and tries_left 2.
      do_reset();
      for (int i = 0; i < 5; i++) win_round(4'(i + 1));
      random_n = 4'd8;
      press();
      guess = 4'd1;
      press();
      chk_all("pre_rst", 1, 1, 2, 5);
      submit       = 1'b0;
      tick();
      master_reset = 1'b1;
      submit       = 1'b1;
      tick();
      chk_all("mid_rst", 0, 0, 0, 0);
      master_reset = 1'b0;

      // Saturation: 256 wins, score pins at 255.
      do_reset();
      for (int i = 0; i < 255; i++) win_round(4'(i));
      chk("score_255", int'(score), 255);
      random_n = 4'd4;
      press();
      guess = 4'd4;
      press();
      chk_all("sat_win", 2, 3, 3, 255);

      // Restart from WIN keeps score; next round latches the new random_n.
      press();
      chk_all("restart", 0, 0, 3, 255);
      random_n = 4'd6;
      press();
      random_n = 4'd1;
      guess    = 4'd5;
      press();
      chk_all("new_tgt_low", 1, 1, 2, 255);
      guess = 4'd6;
      press();
      chk_all("new_tgt_hit", 2, 3, 2, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
